// File: rtl/exwb_stage.sv
// Execute-to-writeback stage: captures ALU result/flags, resolves BNE/BLT into a one-cycle redirect.
// Optional EXWB_PERF_CNT_EN adds retired/taken-branch performance counters.
module exwb_stage #(
  parameter int unsigned W    = 8,
  parameter int unsigned RA_W = 3,
  parameter int unsigned PC_W = 8
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            wb_stall,
  input  logic [2:0]      ex_op,
  input  logic            ex_wr_en,
  input  logic [RA_W-1:0] ex_wr_addr,
  input  logic [W-1:0]    ex_result,
  input  logic            ex_cout,
  input  logic            ex_ovout,
  input  logic            ex_ne,
  input  logic            ex_lt,
  input  logic            ex_is_bne,
  input  logic            ex_is_blt,
  input  logic [PC_W-1:0] ex_target,
  output logic            wb_valid,
  output logic            wb_wr_en,
  output logic [RA_W-1:0] wb_wr_addr,
  output logic [W-1:0]    wb_data,
  output logic            carry_flag,
  output logic            ov_flag,
  output logic            br_taken,
  output logic [PC_W-1:0] br_target
`ifdef EXWB_PERF_CNT_EN
  ,
  output logic [15:0]     perf_retired,
  output logic [15:0]     perf_taken
`endif
);

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

  state_t state, state_d;
  logic   acc, take, is_br, wr_en_q;

  // Start has priority over accept, so an instruction presented with start is dropped.
  assign ex_ready = !wb_stall;
  assign br_taken = (state == REDIRECT);
  assign acc      = ex_valid & ex_ready & !br_taken & !start;
  assign is_br    = ex_is_bne | ex_is_blt;
  assign take     = acc & ((ex_is_bne & ex_ne) | (ex_is_blt & ex_lt));
  assign wb_wr_en = wb_valid & wr_en_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)      state <= RUN;
    else if (start) state <= RUN;
    else            state <= state_d;
  end

  // REDIRECT lasts exactly one cycle, stall or not.
  always_comb begin
    state_d = state;
    case (state)
      RUN:      if (take) state_d = REDIRECT;
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wb_valid   <= 1'b0;
      wr_en_q    <= 1'b0;
      wb_wr_addr <= '0;
      wb_data    <= '0;
      carry_flag <= 1'b0;
      ov_flag    <= 1'b0;
      br_target  <= '0;
    end else if (start) begin
      wb_valid   <= 1'b0;
      carry_flag <= 1'b0;
      ov_flag    <= 1'b0;
    end else if (!wb_stall) begin
      wb_valid <= acc;
      if (acc) begin
        wr_en_q    <= ex_wr_en & !is_br;
        wb_wr_addr <= ex_wr_addr;
        wb_data    <= ex_result;
        case (ex_op)
          3'b000:                 carry_flag <= ex_cout;
          3'b010, 3'b100, 3'b110: ov_flag    <= ex_ovout;
          3'b011, 3'b101:         ov_flag    <= 1'b0;
          default:                ;
        endcase
      end
      if (take) br_target <= ex_target;
    end
  end

`ifdef EXWB_PERF_CNT_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      perf_retired <= '0;
      perf_taken   <= '0;
    end else if (start) begin
      perf_retired <= '0;
      perf_taken   <= '0;
    end else begin
      if (acc && !take) perf_retired <= perf_retired + 16'd1;
      if (take)         perf_taken   <= perf_taken + 16'd1;
    end
  end
`endif

endmodule

// File: doc/exwb_stage.md
# exwb_stage

Execute-to-writeback pipeline stage placed directly downstream of the 8-bit ALU. It captures the ALU result and status outputs into a writeback register and keeps the architectural carry and overflow flags that feed back into the ALU's carry-in and overflow-in. It also resolves BNE/BLT from the ALU compare outputs and produces a one-cycle redirect/flush pulse. A valid/ready handshake lets memory stalls freeze the stage.

## Interface
- `W`, default 8: datapath width.
- `RA_W`, default 3: register-file address width.
- `PC_W`, default 8: branch target width.
- `CLK` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: synchronous program start; clears flags and pipeline state.
- `ex_valid` in 1: an EX instruction is presented.
- `ex_ready` out 1: the stage accepts this cycle; equals `!wb_stall`.
- `wb_stall` in 1: downstream (register file/memory) cannot take a writeback.
- `ex_op` in 3: ALU opcode (000 ADD/ADDRC … 111 SUB).
- `ex_wr_en` in 1: the instruction writes the register file.
- `ex_wr_addr` in RA_W: destination register.
- `ex_result` in W: ALU `data_out`.
- `ex_cout`, `ex_ovout` in 1: ALU carry-out and overflow-out.
- `ex_ne`, `ex_lt` in 1: ALU zero (A!=B) and less-than outputs.
- `ex_is_bne`, `ex_is_blt` in 1: branch decode.
- `ex_target` in PC_W: branch target.
- `wb_valid` out 1: the writeback register holds a live instruction.
- `wb_wr_en` out 1: register-file write strobe; equals `wb_valid & stored wr_en`.
- `wb_wr_addr` out RA_W: writeback address.
- `wb_data` out W: writeback data.
- `carry_flag` out 1: drives the ALU `Cin_alu`.
- `ov_flag` out 1: drives the ALU `OVin_alu`.
- `br_taken` out 1: one-cycle redirect pulse; doubles as the fetch/decode flush.
- `br_target` out PC_W: redirect address, valid while `br_taken` is high.

## Operation
- Accept: `acc = ex_valid & ex_ready & !br_taken`.
  - While `br_taken` is high, the presented EX instruction is squashed. It is treated as accepted for handshake purposes, but nothing is captured and no flags change.
- On `acc`:
  - `wb_valid` is set to 1.
  - `wr_en`, `wr_addr` and `result` are captured.
  - Flags update per the rules below.
- Not accepted and not stalled: `wb_valid` is cleared to 0.
- Stalled (`wb_stall=1`): all state holds, including the flags and `br_taken`.
  - `br_taken` is forced to 0 after one cycle unless a new branch is accepted, so a held pulse never repeats.
- Flag rules, applied only on `acc`:
  - op 000: `carry_flag <= ex_cout`.
  - op 010, 100, 110 (SLLI, SRA, SRL): `ov_flag <= ex_ovout`.
  - op 011, 101 (SLLO, SRO, the consumers): `ov_flag <= 0`.
  - op 001, 111: no flag change.
- Branch: `take = acc & ((ex_is_bne & ex_ne) | (ex_is_blt & ex_lt))`.
  - Next cycle: `br_taken <= take` and `br_target <= ex_target`.
  - Branches never write: the captured `wr_en` is forced to 0 when `ex_is_bne | ex_is_blt`.
- State machine, 2 states:
  - RUN → REDIRECT on `take`.
  - REDIRECT → RUN unconditionally after 1 cycle. This holds under stall as well: the pulse width is exactly 1 cycle.
  - `br_taken = (state==REDIRECT)`.
- Priority: `reset` > `start` > stall > accept.
  - `start` clears `wb_valid`, both flags and `br_taken`, and returns to RUN. It ignores `ex_valid` in the same cycle.

## Timing
- Reset values:
  - `wb_valid`, `wb_wr_en`, `carry_flag`, `ov_flag`, `br_taken` = 0.
  - `wb_wr_addr` = 0, `wb_data` = 0, `br_target` = 0.
  - State = RUN.
- Latency: EX inputs appear on the `wb_*` outputs and flags 1 cycle after acceptance.
  - An instruction accepted in cycle N+1 sees flags written by the instruction accepted in cycle N. No forwarding is required.
- `ex_ready` is combinational from `wb_stall` only, with no path from `ex_valid`.
- Branch resolve: `br_taken` is high in the cycle after the branch is accepted, for exactly one cycle. The instruction presented in that cycle is squashed.
- Back-to-back branches: the second branch is in the squash slot and cannot be taken.
- Reset mid-stall or mid-redirect: all outputs go to their reset values immediately (asynchronous).

## Configuration
- `EXWB_PERF_CNT_EN`:
  - Defined: adds outputs `perf_retired` (16-bit count of `acc` cycles with non-branch or not-taken branch instructions) and `perf_taken` (16-bit count of taken branches). Both wrap at 0xFFFF→0 and clear on `reset` and `start`.
  - Undefined: the ports and counters are absent, with zero logic cost.

## Test plan
- Reset, then ADD of result 0x3C with cout=1 → next cycle `wb_data=0x3C`, `wb_wr_en=1`, `carry_flag=1`. A following SUB leaves `carry_flag=1`.
- SLLI with ovout=1, then SLLO → `ov_flag` is 1 after SLLI and 0 after SLLO. `start` mid-sequence → both flags 0 next cycle.
- BNE with ne=1, target 0x42 → `br_taken=1` and `br_target=0x42` for one cycle. The next EX (ADD, wr_en=1) is squashed: no `wb_wr_en`, no flag change.
- BLT with lt=0 → `br_taken` stays 0 and `wb_wr_en=0`. Instruction flow continues.
- Hold `wb_stall=1` for 3 cycles with an ADD presented:
  - `ex_ready=0`; `wb_*` and the flags are unchanged.
  - On release, the ADD is captured 1 cycle later.
  - A stall in the REDIRECT cycle still yields a 1-cycle `br_taken`.
- With `EXWB_PERF_CNT_EN` defined: retire 5 ADDs and 2 taken branches → `perf_retired=5` and `perf_taken=2`. Preload near 0xFFFF → the count wraps to 0.
